execute_sys_reg_pipe: RTL and testbench

Registered, parametrised system-register execute unit for the execute stage. It generalises the combinational system-register path in three ways: configurable data width, a configurable status-register bitfield, and a configurable reload offset. It adds a valid/lock handshake on both sides and a serialising FSM, so IDTS/PS updates commit only after the downstream pipeline has drained. It sits between the execute dispatcher and the writeback/control-reload logic.

---
 rtl/execute_sys_reg_pipe_if.sv | 34 +++
 rtl/execute_sys_reg_pipe.sv | 122 ++++++++++++
 tb/tb_execute_sys_reg_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_sys_reg_pipe_if.sv
// Dispatcher/downstream bundle for the system-register execute unit.
// The slave modport is the unit itself; the master modport drives it.
interface execute_sys_reg_pipe_if #(
    parameter int P_DATA_N = 32
);
    logic                iFLUSH;
    logic                iPREV_VALID;
    logic                oPREV_LOCK;
    logic [4:0]          iCMD;
    logic [P_DATA_N-1:0] iPC;
    logic [P_DATA_N-1:0] iSOURCE0;
    logic [P_DATA_N-1:0] iSOURCE1;
    logic                iPIPE_EMPTY;
    logic                oNEXT_VALID;
    logic                iNEXT_LOCK;
    logic [P_DATA_N-1:0] oOUT;
    logic                oCTRL_IDT_VALID;
    logic                oCTRL_PSR_VALID;
    logic [P_DATA_N-1:0] oCTRL_RELOAD_ADDR;

    modport slave (
        input  iFLUSH, iPREV_VALID, iCMD, iPC, iSOURCE0, iSOURCE1,
               iPIPE_EMPTY, iNEXT_LOCK,
        output oPREV_LOCK, oNEXT_VALID, oOUT, oCTRL_IDT_VALID,
               oCTRL_PSR_VALID, oCTRL_RELOAD_ADDR
    );

    modport master (
        output iFLUSH, iPREV_VALID, iCMD, iPC, iSOURCE0, iSOURCE1,
               iPIPE_EMPTY, iNEXT_LOCK,
        input  oPREV_LOCK, oNEXT_VALID, oOUT, oCTRL_IDT_VALID,
               oCTRL_PSR_VALID, oCTRL_RELOAD_ADDR
    );
endinterface

// File: rtl/execute_sys_reg_pipe.sv
// System-register execute unit with a serialising commit path for IDTS/PS.
// Latency: 1 cycle for normal ops; control ops drain the pipe, then commit.
// Backpressure: output register holds under iNEXT_LOCK; oPREV_LOCK stalls dispatch.
module execute_sys_reg_pipe #(
    parameter int P_DATA_N        = 32,
    parameter int P_FIELD_LSB     = 2,
    parameter int P_FIELD_W       = 1,
    parameter int P_RELOAD_OFFSET = 4
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET_SYNC,
    execute_sys_reg_pipe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;
    typedef enum logic [1:0] {K_NORM, K_IDT, K_PSR} kind_t;

    function automatic logic [P_DATA_N-1:0] field_mask();
        logic [P_DATA_N-1:0] m;
        m = '0;
        for (int i = 0; i < P_DATA_N; i++) begin
            if (i < P_FIELD_W) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [P_DATA_N-1:0] FIELD_MASK = field_mask();

    state_t              state;
    logic                out_vld;
    logic [P_DATA_N-1:0] out_dat;
    kind_t               out_kind;
    logic [P_DATA_N-1:0] out_addr;
    logic [P_DATA_N-1:0] hold_dat;
    kind_t               hold_kind;
    logic [P_DATA_N-1:0] hold_addr;

    logic [P_DATA_N-1:0] res_dat;
    kind_t               res_kind;
    logic [P_DATA_N-1:0] res_addr;
    logic                lock;
    logic                xfer;
    logic                accept;

    always_comb begin
        res_dat  = bus.iSOURCE0;
        res_kind = K_NORM;
        case (bus.iCMD)
            5'd1: res_dat = bus.iSOURCE1;
            5'd2: res_dat = (bus.iSOURCE0 >> P_FIELD_LSB) & FIELD_MASK;
            5'd3: res_dat = (bus.iSOURCE0 & ~(FIELD_MASK << P_FIELD_LSB))
                          | ((bus.iSOURCE1 & FIELD_MASK) << P_FIELD_LSB);
            5'd4: res_kind = K_IDT;
            5'd5: res_kind = K_PSR;
            default: ;
        endcase
    end

    assign res_addr = bus.iPC + P_DATA_N'(P_RELOAD_OFFSET);
    assign xfer     = out_vld && !bus.iNEXT_LOCK;
    assign lock     = (state != IDLE) || (out_vld && bus.iNEXT_LOCK);
    assign accept   = bus.iPREV_VALID && !lock && !bus.iFLUSH;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state     <= IDLE;
            out_vld   <= 1'b0;
            out_dat   <= '0;
            out_kind  <= K_NORM;
            out_addr  <= '0;
            hold_dat  <= '0;
            hold_kind <= K_NORM;
            hold_addr <= '0;
        end else if (bus.iFLUSH) begin
            // Data and reload address keep their last values; only validity is dropped.
            state   <= IDLE;
            out_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && res_kind == K_NORM) begin
                        out_vld  <= 1'b1;
                        out_dat  <= res_dat;
                        out_kind <= K_NORM;
                        out_addr <= res_addr;
                    end else begin
                        if (xfer) out_vld <= 1'b0;
                        if (accept) begin
                            hold_dat  <= res_dat;
                            hold_kind <= res_kind;
                            hold_addr <= res_addr;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) out_vld <= 1'b0;
                    if (bus.iPIPE_EMPTY && (!out_vld || xfer)) begin
                        out_vld  <= 1'b1;
                        out_dat  <= hold_dat;
                        out_kind <= hold_kind;
                        out_addr <= hold_addr;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (xfer) begin
                        out_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oPREV_LOCK        = lock;
    assign bus.oNEXT_VALID       = out_vld;
    assign bus.oOUT              = out_dat;
    assign bus.oCTRL_RELOAD_ADDR = out_addr;
    assign bus.oCTRL_IDT_VALID   = xfer && (out_kind == K_IDT);
    assign bus.oCTRL_PSR_VALID   = xfer && (out_kind == K_PSR);
endmodule

// File: tb/tb_execute_sys_reg_pipe.sv
// Scoreboard bench: the driver pushes expected results at accept, a negedge
// monitor pops and compares on every downstream transfer.
module tb_execute_sys_reg_pipe;
    localparam int LSB = 2;
    localparam int W   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_sys_reg_pipe_if #(.P_DATA_N(32)) sif ();
    execute_sys_reg_pipe_if #(.P_DATA_N(32)) sif2 ();

    execute_sys_reg_pipe #(.P_DATA_N(32), .P_FIELD_LSB(2), .P_FIELD_W(1),
                           .P_RELOAD_OFFSET(4))
        dut (.iCLOCK(clk), .iRESET_SYNC(rst), .bus(sif));

    execute_sys_reg_pipe #(.P_DATA_N(32), .P_FIELD_LSB(8), .P_FIELD_W(4),
                           .P_RELOAD_OFFSET(4))
        dut2 (.iCLOCK(clk), .iRESET_SYNC(rst), .bus(sif2));

    typedef struct {
        logic [31:0] dat;
        int          kind;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_mode = 0;
    bit   mon_en = 0;
    int   vcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from the field rules, using plain arithmetic.
    function automatic logic [31:0] model(input int cmd, input logic [31:0] s0, input logic [31:0] s1);
        longint unsigned a, b, f, p, m;
        a = s0; b = s1; p = 64'd1 << LSB; m = 64'd1 << W;
        f = (a / p) % m;
        case (cmd)
            1: return s1;
            2: return 32'(f);
            3: return 32'(a - f * p + (b % m) * p);
            default: return s0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            sif.iNEXT_LOCK  = ($urandom_range(0, 9) < 3);
            sif.iPIPE_EMPTY = ($urandom_range(0, 9) < 6);
        end
    endtask

    task automatic issue(input int cmd, input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1);
        exp_t e;
        bit   done;
        done = 0;
        sif.iPREV_VALID = 1'b1;
        sif.iCMD        = 5'(cmd);
        sif.iPC         = pc;
        sif.iSOURCE0    = s0;
        sif.iSOURCE1    = s1;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            if (!sif.oPREV_LOCK) begin
                e.dat  = model(cmd, s0, s1);
                e.kind = (cmd == 4 || cmd == 5) ? cmd : 0;
                e.addr = pc + 32'd4;
                q.push_back(e);
                done = 1;
            end
            tick();
        end
        sif.iPREV_VALID = 1'b0;
        if (!done) check("issue_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sif.oCTRL_IDT_VALID && sif.oCTRL_PSR_VALID) check("both_strobes", 1, 0);
            if (sif.oNEXT_VALID && !sif.iNEXT_LOCK) begin
                if (q.size() == 0) begin
                    check("unexpected_xfer", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", sif.oOUT, e.dat);
                    check("idt_strobe", sif.oCTRL_IDT_VALID, e.kind == 4);
                    check("psr_strobe", sif.oCTRL_PSR_VALID, e.kind == 5);
                    if (e.kind != 0) check("reload_addr", sif.oCTRL_RELOAD_ADDR, e.addr);
                end
            end
        end
    end

    initial begin
        sif.iFLUSH = 0; sif.iPREV_VALID = 0; sif.iCMD = 0; sif.iPC = 0;
        sif.iSOURCE0 = 0; sif.iSOURCE1 = 0; sif.iPIPE_EMPTY = 1; sif.iNEXT_LOCK = 0;
        sif2.iFLUSH = 0; sif2.iPREV_VALID = 0; sif2.iCMD = 0; sif2.iPC = 0;
        sif2.iSOURCE0 = 0; sif2.iSOURCE1 = 0; sif2.iPIPE_EMPTY = 1; sif2.iNEXT_LOCK = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check("rst_valid", sif.oNEXT_VALID, 0);
        check("rst_out", sif.oOUT, 0);
        check("rst_addr", sif.oCTRL_RELOAD_ADDR, 0);
        check("rst_lock", sif.oPREV_LOCK, 0);
        check("rst_strobes", {sif.oCTRL_IDT_VALID, sif.oCTRL_PSR_VALID}, 0);
        mon_en = 1;
        tick();

        // Latency-1 normal op
        issue(1, 32'h0, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        check("buf1_valid", sif.oNEXT_VALID, 1);
        check("buf1_out", sif.oOUT, 32'hDEADBEEF);
        tick();

        // Four back-to-back ops give four consecutive valid cycles
        vcnt = 0;
        fork
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (sif.oNEXT_VALID) vcnt++;
                end
            end
        join_none
        for (int i = 0; i < 4; i++) issue(0, 32'h10 * i, $urandom, $urandom);
        tick(); tick();
        check("b2b_valid_cycles", vcnt, 4);

        // Bitfield ops with the default field
        issue(3, 32'h0, 32'hFFFF_FFFB, 32'h1);
        @(negedge clk);
        check("field_w", sif.oOUT, 32'hFFFF_FFFF);
        tick();
        issue(2, 32'h0, 32'h4, 32'h0);
        @(negedge clk);
        check("field_r", sif.oOUT, 32'h1);
        tick();

        // IDTS waits for an empty pipe
        sif.iPIPE_EMPTY = 0;
        issue(4, 32'h100, 32'h55, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_lock", sif.oPREV_LOCK, 1);
            check("drain_no_strobe", sif.oCTRL_IDT_VALID, 0);
            tick();
        end
        sif.iPIPE_EMPTY = 1;
        @(negedge clk);
        check("idt_early", sif.oCTRL_IDT_VALID, 0);
        tick();
        @(negedge clk);
        check("idt_strobe_time", sif.oCTRL_IDT_VALID, 1);
        check("idt_addr", sif.oCTRL_RELOAD_ADDR, 32'h104);
        tick();
        @(negedge clk);
        check("idt_single", sif.oCTRL_IDT_VALID, 0);
        check("idt_unlock", sif.oPREV_LOCK, 0);
        tick();

        // PS held in COMMIT by downstream lock
        sif.iNEXT_LOCK = 1;
        issue(5, 32'h200, 32'h77, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ps_hold_valid", sif.oNEXT_VALID, 1);
            check("ps_hold_no_strobe", sif.oCTRL_PSR_VALID, 0);
            tick();
        end
        sif.iNEXT_LOCK = 0;
        @(negedge clk);
        check("ps_strobe", sif.oCTRL_PSR_VALID, 1);
        tick();
        @(negedge clk);
        check("ps_single", sif.oCTRL_PSR_VALID, 0);
        tick();

        // Flush during DRAIN discards the control op
        sif.iPIPE_EMPTY = 0;
        issue(4, 32'h300, 32'h99, 32'h0);
        sif.iFLUSH = 1;
        tick();
        sif.iFLUSH = 0;
        q.delete();
        @(negedge clk);
        check("flush_valid", sif.oNEXT_VALID, 0);
        check("flush_lock", sif.oPREV_LOCK, 0);
        check("flush_no_strobe", sif.oCTRL_IDT_VALID, 0);
        sif.iPIPE_EMPTY = 1;
        tick();
        issue(0, 32'h400, 32'h1234, 32'h0);
        tick(); tick();
        check("flush_followup", q.size(), 0);

        // Reset while in COMMIT
        sif.iNEXT_LOCK = 1;
        issue(4, 32'h500, 32'hAB, 32'h0);
        tick();
        @(negedge clk);
        check("commit_valid", sif.oNEXT_VALID, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        q.delete();
        @(negedge clk);
        check("rst2_valid", sif.oNEXT_VALID, 0);
        check("rst2_out", sif.oOUT, 0);
        check("rst2_addr", sif.oCTRL_RELOAD_ADDR, 0);
        check("rst2_lock", sif.oPREV_LOCK, 0);
        sif.iNEXT_LOCK = 0;
        tick();
        issue(3, 32'hFFFF_FFFC, 32'h0, 32'h1);
        issue(4, 32'hFFFF_FFFC, 32'hC0DE, 32'h0);
        @(negedge clk);
        check("wrap_drain_no_strobe", sif.oCTRL_IDT_VALID, 0);
        tick();
        @(negedge clk);
        check("wrap_strobe", sif.oCTRL_IDT_VALID, 1);
        check("wrap_addr", sif.oCTRL_RELOAD_ADDR, 32'h0);
        tick();

        // Wider field on the second instance
        sif2.iPREV_VALID = 1; sif2.iCMD = 5'd2; sif2.iSOURCE0 = 32'h0000_0A00;
        tick();
        sif2.iCMD = 5'd3; sif2.iSOURCE0 = 32'hFFFF_FFFF; sif2.iSOURCE1 = 32'h5;
        @(negedge clk);
        check("wide_field_r", sif2.oOUT, 32'hA);
        tick();
        sif2.iPREV_VALID = 0;
        @(negedge clk);
        check("wide_field_w", sif2.oOUT, 32'hFFFF_F5FF);
        tick();

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            int c;
            c = $urandom_range(0, 9);
            if (c > 5) c = $urandom_range(6, 31);
            issue(c, $urandom, $urandom, $urandom);
        end
        rand_mode = 0;
        sif.iNEXT_LOCK = 0;
        sif.iPIPE_EMPTY = 1;
        for (int g = 0; g < 50 && q.size() != 0; g++) tick();
        check("final_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
